mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter xlen, default 32: width of addresses and data words.
REQ-002 Parameter timeout, default 64: cycles to wait for a memory response before an error response is forced.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 i_req_v  input  1  instruction-fetch read request; held until i_ready.
REQ-006 i_adr  input  xlen  fetch address.
REQ-007 i_ready  output  1  fetch request accepted this cycle.
REQ-008 i_resp / i_resp_v / i_resp_error  output  xlen/1/1  fetch response data, valid pulse, error flag.
REQ-009 d_r_v / d_w_v  input  1/1  data read / write request; held until d_ready.
REQ-010 d_adr / d_data / d_strobe  input  xlen/xlen/4  data address, write data, byte strobes.
REQ-011 d_ready  output  1  data request accepted this cycle.
REQ-012 d_resp / d_resp_v / d_resp_error  output  xlen/1/1  data response data, valid pulse, error flag.
REQ-013 m_r_v / m_w_v / m_adr / m_data / m_strobe  output  1/1/xlen/xlen/4  shared memory request port.
REQ-014 m_resp / m_resp_v / m_resp_error  input  xlen/1/1  shared memory response port.

Function
REQ-015 FSM states IDLE, WAIT_I, WAIT_D; at most one memory transaction outstanding.
REQ-016 IDLE, only fetch pending: i_ready=1 same cycle, next state WAIT_I.
REQ-017 IDLE, only data pending (d_r_v|d_w_v): d_ready=1 same cycle, next state WAIT_D.
REQ-018 IDLE, both pending: grant data unless last_grant==data, then grant fetch; last_grant updates on every grant.
REQ-019 Memory request registered: m_* driven in cycle N+1 after grant in cycle N, m_r_v/m_w_v high for exactly one cycle, low otherwise.
REQ-020 Fetch grant drives m_r_v=1, m_w_v=0, m_strobe=0, m_data=0.
REQ-021 d_r_v and d_w_v both high: issued as write only (m_w_v=1, m_r_v=0).
REQ-022 WAIT_x, m_resp_v=1 in cycle M: owner's resp/resp_v/resp_error registered, valid in M+1 for one cycle; other requester's resp_v stays 0; next state IDLE.
REQ-023 New grant permitted in the IDLE cycle following the response cycle M (back-to-back throughput: one transaction per 3 cycles plus memory latency).
REQ-024 Timeout counter cleared on grant, increments each WAIT_x cycle; on reaching timeout without m_resp_v: owner gets resp_v=1, resp_error=1, resp=0; next IDLE.
REQ-025 m_resp_v in IDLE (late/spurious): discarded, no resp_v asserted.
REQ-026 m_resp_v in the same cycle the counter reaches timeout: real response wins, error=m_resp_error.
REQ-027 i_ready and d_ready never high in the same cycle, never high outside IDLE.

Reset
REQ-028 rst_n low: state=IDLE, last_grant=fetch, counter=0, all outputs 0, effective immediately without clock.
REQ-029 Reset mid-transaction abandons it; no response delivered to either requester after reset release.

Structure
REQ-030 xlen from shared package cpu_parameters; arb_state_t enum (IDLE, WAIT_I, WAIT_D) added to cpu_parameters.
REQ-031 One sub-module natural: mem_arb_timer (clear/enable/expired counter, width clog2(timeout+1)).

Verification
REQ-032 Fetch only, i_adr=0x10000, memory responds 0x00000013 after 1 cycle -> m_r_v pulse at 0x10000, i_resp=0x00000013 with i_resp_v one cycle, d_resp_v=0.
REQ-033 Write only, d_adr=0x20004, d_data=0xDEADBEEF, d_strobe=0xF -> single m_w_v pulse with those values, d_resp_v after m_resp_v.
REQ-034 Fetch and data held simultaneously for 4 transactions from reset -> grant order data, fetch, data, fetch.
REQ-035 Fetch granted, memory silent -> i_resp_v=1, i_resp_error=1, i_resp=0 exactly timeout cycles after grant; later m_resp_v ignored.
REQ-036 rst_n low during WAIT_D -> all outputs 0 asynchronously; after release, pending m_resp_v produces no d_resp_v.
REQ-037 d_r_v=d_w_v=1 -> m_w_v=1, m_r_v=0.

Source files
------------

// File: rtl/cpu_parameters.sv
// Shared CPU-wide parameters and the memory arbiter's state/grant types.
package cpu_parameters;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned STRB_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_I = 2'd1,
    WAIT_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    GRANT_FETCH = 1'b0,
    GRANT_DATA  = 1'b1
  } grant_t;

endpackage

// File: rtl/mem_arb_timer.sv
// Response watchdog: counts wait cycles and flags the cycle whose increment reaches timeout.
module mem_arb_timer #(
  parameter int unsigned timeout = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = (timeout < 2) ? 1 : $clog2(timeout + 1);

  logic [CNT_W-1:0] cnt;

  assign expired = enable && (cnt == CNT_W'(timeout - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) arbiter onto a single memory port, one transaction in flight.
module mem_arbiter
  import cpu_parameters::*;
#(
  parameter int unsigned xlen    = XLEN,
  parameter int unsigned timeout = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req_v,
  input  logic [xlen-1:0]   i_adr,
  output logic              i_ready,
  output logic [xlen-1:0]   i_resp,
  output logic              i_resp_v,
  output logic              i_resp_error,
  input  logic              d_r_v,
  input  logic              d_w_v,
  input  logic [xlen-1:0]   d_adr,
  input  logic [xlen-1:0]   d_data,
  input  logic [STRB_W-1:0] d_strobe,
  output logic              d_ready,
  output logic [xlen-1:0]   d_resp,
  output logic              d_resp_v,
  output logic              d_resp_error,
  output logic              m_r_v,
  output logic              m_w_v,
  output logic [xlen-1:0]   m_adr,
  output logic [xlen-1:0]   m_data,
  output logic [STRB_W-1:0] m_strobe,
  input  logic [xlen-1:0]   m_resp,
  input  logic              m_resp_v,
  input  logic              m_resp_error
);

  arb_state_t        state, state_nxt;
  grant_t            last_grant, last_grant_nxt;
  logic              m_r_v_nxt, m_w_v_nxt;
  logic [xlen-1:0]   m_adr_nxt, m_data_nxt;
  logic [STRB_W-1:0] m_strobe_nxt;
  logic [xlen-1:0]   i_resp_nxt, d_resp_nxt;
  logic              i_resp_v_nxt, i_resp_error_nxt;
  logic              d_resp_v_nxt, d_resp_error_nxt;
  logic              tmr_clear, tmr_enable, tmr_expired;
  logic              d_pend;

  assign d_pend     = d_r_v | d_w_v;
  assign tmr_enable = (state == WAIT_I) || (state == WAIT_D);

  mem_arb_timer #(.timeout(timeout)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (tmr_clear),
    .enable  (tmr_enable),
    .expired (tmr_expired)
  );

  // Next-state, grant and response decode; readies are gated by rst_n so reset silences them at once.
  always_comb begin
    state_nxt        = state;
    last_grant_nxt   = last_grant;
    m_r_v_nxt        = 1'b0;
    m_w_v_nxt        = 1'b0;
    m_adr_nxt        = m_adr;
    m_data_nxt       = m_data;
    m_strobe_nxt     = m_strobe;
    i_resp_nxt       = i_resp;
    i_resp_v_nxt     = 1'b0;
    i_resp_error_nxt = 1'b0;
    d_resp_nxt       = d_resp;
    d_resp_v_nxt     = 1'b0;
    d_resp_error_nxt = 1'b0;
    i_ready          = 1'b0;
    d_ready          = 1'b0;
    tmr_clear        = 1'b0;

    unique case (state)
      IDLE: begin
        if (rst_n) begin
          if (d_pend && (!i_req_v || last_grant == GRANT_FETCH)) begin
            d_ready        = 1'b1;
            last_grant_nxt = GRANT_DATA;
            state_nxt      = WAIT_D;
            tmr_clear      = 1'b1;
            // A simultaneous read+write is issued as a write.
            m_w_v_nxt      = d_w_v;
            m_r_v_nxt      = !d_w_v;
            m_adr_nxt      = d_adr;
            m_data_nxt     = d_w_v ? d_data : '0;
            m_strobe_nxt   = d_w_v ? d_strobe : '0;
          end else if (i_req_v) begin
            i_ready        = 1'b1;
            last_grant_nxt = GRANT_FETCH;
            state_nxt      = WAIT_I;
            tmr_clear      = 1'b1;
            m_r_v_nxt      = 1'b1;
            m_adr_nxt      = i_adr;
            m_data_nxt     = '0;
            m_strobe_nxt   = '0;
          end
        end
      end
      WAIT_I: begin
        if (m_resp_v) begin
          i_resp_nxt       = m_resp;
          i_resp_v_nxt     = 1'b1;
          i_resp_error_nxt = m_resp_error;
          state_nxt        = IDLE;
        end else if (tmr_expired) begin
          i_resp_nxt       = '0;
          i_resp_v_nxt     = 1'b1;
          i_resp_error_nxt = 1'b1;
          state_nxt        = IDLE;
        end
      end
      WAIT_D: begin
        if (m_resp_v) begin
          d_resp_nxt       = m_resp;
          d_resp_v_nxt     = 1'b1;
          d_resp_error_nxt = m_resp_error;
          state_nxt        = IDLE;
        end else if (tmr_expired) begin
          d_resp_nxt       = '0;
          d_resp_v_nxt     = 1'b1;
          d_resp_error_nxt = 1'b1;
          state_nxt        = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_grant   <= GRANT_FETCH;
      m_r_v        <= 1'b0;
      m_w_v        <= 1'b0;
      m_adr        <= '0;
      m_data       <= '0;
      m_strobe     <= '0;
      i_resp       <= '0;
      i_resp_v     <= 1'b0;
      i_resp_error <= 1'b0;
      d_resp       <= '0;
      d_resp_v     <= 1'b0;
      d_resp_error <= 1'b0;
    end else begin
      state        <= state_nxt;
      last_grant   <= last_grant_nxt;
      m_r_v        <= m_r_v_nxt;
      m_w_v        <= m_w_v_nxt;
      m_adr        <= m_adr_nxt;
      m_data       <= m_data_nxt;
      m_strobe     <= m_strobe_nxt;
      i_resp       <= i_resp_nxt;
      i_resp_v     <= i_resp_v_nxt;
      i_resp_error <= i_resp_error_nxt;
      d_resp       <= d_resp_nxt;
      d_resp_v     <= d_resp_v_nxt;
      d_resp_error <= d_resp_error_nxt;
    end
  end

endmodule
